// File: rtl/shift_arbiter_pkg.sv
// shift_arbiter shared definitions: op and state encodings, widths,
// and the bit-reversal helper used to build right shifts from a left shifter.
package shift_arbiter_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_ROTL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_ROT2 = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    function automatic logic [DATA_W-1:0] bitrev(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = x[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// shift_arbiter bus: two valid/ready request ports and the shared
// response pulses; master = requesters, slave = the arbiter.
interface shift_arbiter_if;
    import shift_arbiter_pkg::*;

    logic               req0_valid;
    logic               req0_ready;
    logic [1:0]         req0_op;
    logic [DATA_W-1:0]  req0_a;
    logic [SHAMT_W-1:0] req0_s;

    logic               req1_valid;
    logic               req1_ready;
    logic [1:0]         req1_op;
    logic [DATA_W-1:0]  req1_a;
    logic [SHAMT_W-1:0] req1_s;

    logic               resp0_valid;
    logic               resp1_valid;
    logic [DATA_W-1:0]  resp_data;
    logic               busy;

    modport master (
        output req0_valid, req0_op, req0_a, req0_s,
        output req1_valid, req1_op, req1_a, req1_s,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_data, busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_s,
        input  req1_valid, req1_op, req1_a, req1_s,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_data, busy
    );

endinterface

// File: rtl/shift_arbiter_rr_arb.sv
// shift_rr_arb: 2-way grant logic; with RR_EN a tie goes to the port
// not granted last, otherwise port 0 always wins.
module shift_rr_arb #(
    parameter bit RR_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

    logic last_grant;

    // Port 0 wins unless port 1 is due its turn on a tie.
    always_comb begin
        grant0 = enable & valid0 & (~valid1 | ~RR_EN | last_grant);
        grant1 = enable & valid1 & ~grant0;
    end

    // Remember which port was served; reset favours port 0 next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant0 | grant1) begin
            last_grant <= grant1;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one left barrel shifter; right
// shifts via bit reversal. SHIFT_ROTATE_EN enables the two-pass ROTL.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_arbiter_if.slave bus
);

    state_e             state;
    op_e                op_q;
    logic [DATA_W-1:0]  a_q;
    logic [SHAMT_W-1:0] s_q;
    logic               port_q;
    logic [DATA_W-1:0]  result_q;
    logic               resp0_q;
    logic               resp1_q;

    logic               grant0;
    logic               grant1;

    logic [DATA_W-1:0]  sh_in;
    logic [SHAMT_W-1:0] sh_amt;
    logic [DATA_W-1:0]  sh_out;
    logic [DATA_W-1:0]  rev_out;
    logic [DATA_W-1:0]  fill;
    logic [DATA_W-1:0]  exec_res;
`ifdef SHIFT_ROTATE_EN
    logic [DATA_W-1:0]  rot_res;
`endif

    shift_rr_arb #(
        .RR_EN (RR_EN)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state == ST_IDLE),
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign bus.req0_ready  = grant0 & rst_n;
    assign bus.req1_ready  = grant1 & rst_n;
    assign bus.resp0_valid = resp0_q;
    assign bus.resp1_valid = resp1_q;
    assign bus.resp_data   = result_q;
    assign bus.busy        = (state != ST_IDLE);

    // Select shared shifter operand and amount for the current pass.
    always_comb begin
        sh_in  = a_q;
        sh_amt = s_q;
        if (op_q == OP_SRL || op_q == OP_SRA) begin
            sh_in = bitrev(a_q);
        end
`ifdef SHIFT_ROTATE_EN
        if (state == ST_ROT2) begin
            sh_in  = bitrev(a_q);
            sh_amt = SHAMT_W'(0) - s_q;
        end
`endif
    end

    assign sh_out  = sh_in << sh_amt;
    assign rev_out = bitrev(sh_out);

    // Sign-fill mask for SRA: the top s bits of the result.
    always_comb begin
        fill = '0;
        for (int i = 0; i < DATA_W; i++) begin
            fill[i] = (i + int'(s_q)) > (DATA_W - 1);
        end
    end

    // First-pass result for each op.
    always_comb begin
        exec_res = a_q;
        case (op_q)
            OP_SLL:  exec_res = sh_out;
            OP_SRL:  exec_res = rev_out;
            OP_SRA:  exec_res = rev_out | (a_q[DATA_W-1] ? fill : '0);
`ifdef SHIFT_ROTATE_EN
            OP_ROTL: exec_res = sh_out;
`else
            OP_ROTL: exec_res = a_q;
`endif
            default: exec_res = a_q;
        endcase
    end

`ifdef SHIFT_ROTATE_EN
    assign rot_res = rev_out | result_q;
`endif

    // Sequencer: accept, execute, optional rotate pass, respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            op_q     <= OP_SLL;
            a_q      <= '0;
            s_q      <= '0;
            port_q   <= 1'b0;
            result_q <= '0;
            resp0_q  <= 1'b0;
            resp1_q  <= 1'b0;
        end else begin
            resp0_q <= 1'b0;
            resp1_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant1) begin
                        op_q   <= op_e'(bus.req1_op);
                        a_q    <= bus.req1_a;
                        s_q    <= bus.req1_s;
                        port_q <= 1'b1;
                        state  <= ST_EXEC;
                    end else if (grant0) begin
                        op_q   <= op_e'(bus.req0_op);
                        a_q    <= bus.req0_a;
                        s_q    <= bus.req0_s;
                        port_q <= 1'b0;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q <= exec_res;
`ifdef SHIFT_ROTATE_EN
                    if (op_q == OP_ROTL) begin
                        state <= ST_ROT2;
                    end else begin
                        state   <= ST_DONE;
                        resp0_q <= ~port_q;
                        resp1_q <= port_q;
                    end
`else
                    state   <= ST_DONE;
                    resp0_q <= ~port_q;
                    resp1_q <= port_q;
`endif
                end
`ifdef SHIFT_ROTATE_EN
                ST_ROT2: begin
                    result_q <= rot_res;
                    state    <= ST_DONE;
                    resp0_q  <= ~port_q;
                    resp1_q  <= port_q;
                end
`endif
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
